// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan decoder: segment bit positions,
// the 16 hex glyph codes and the capture FSM state type.
package seg_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_CODE_0 = 7'h7E;
  localparam logic [6:0] SEG_CODE_1 = 7'h30;
  localparam logic [6:0] SEG_CODE_2 = 7'h6D;
  localparam logic [6:0] SEG_CODE_3 = 7'h79;
  localparam logic [6:0] SEG_CODE_4 = 7'h33;
  localparam logic [6:0] SEG_CODE_5 = 7'h5B;
  localparam logic [6:0] SEG_CODE_6 = 7'h5F;
  localparam logic [6:0] SEG_CODE_7 = 7'h70;
  localparam logic [6:0] SEG_CODE_8 = 7'h7F;
  localparam logic [6:0] SEG_CODE_9 = 7'h73;
  localparam logic [6:0] SEG_CODE_A = 7'h77;
  localparam logic [6:0] SEG_CODE_B = 7'h1F;
  localparam logic [6:0] SEG_CODE_C = 7'h4E;
  localparam logic [6:0] SEG_CODE_D = 7'h3D;
  localparam logic [6:0] SEG_CODE_E = 7'h4F;
  localparam logic [6:0] SEG_CODE_F = 7'h47;

  typedef enum logic [0:0] {
    StCollect = 1'b0,
    StHold    = 1'b1
  } seg_state_e;

endpackage

// File: rtl/seg_scan_decoder_if.sv
// Display-bus sample inputs plus the recovered-frame valid/ready output channel.
interface seg_scan_decoder_if #(
  parameter int unsigned DIGITS = 4
);
  logic [DIGITS-1:0]   digitSel;
  logic [6:0]          segMask;
  logic                outValid;
  logic                outReady;
  logic [4*DIGITS-1:0] outWord;
  logic                outErr;

  modport master (
    output digitSel, segMask, outReady,
    input  outValid, outWord, outErr
  );

  modport slave (
    input  digitSel, segMask, outReady,
    output outValid, outWord, outErr
  );
endinterface

// File: rtl/seg_pattern_decode.sv
// Combinational 7-segment mask to hex nibble decoder; unknown masks give valid=0, nibble=0.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_mask,
  output logic       o_valid,
  output logic [3:0] o_nibble
);

  always_comb begin
    o_valid  = 1'b1;
    o_nibble = 4'h0;
    unique case (i_mask)
      SEG_CODE_0: o_nibble = 4'h0;
      SEG_CODE_1: o_nibble = 4'h1;
      SEG_CODE_2: o_nibble = 4'h2;
      SEG_CODE_3: o_nibble = 4'h3;
      SEG_CODE_4: o_nibble = 4'h4;
      SEG_CODE_5: o_nibble = 4'h5;
      SEG_CODE_6: o_nibble = 4'h6;
      SEG_CODE_7: o_nibble = 4'h7;
      SEG_CODE_8: o_nibble = 4'h8;
      SEG_CODE_9: o_nibble = 4'h9;
      SEG_CODE_A: o_nibble = 4'hA;
      SEG_CODE_B: o_nibble = 4'hB;
      SEG_CODE_C: o_nibble = 4'hC;
      SEG_CODE_D: o_nibble = 4'hD;
      SEG_CODE_E: o_nibble = 4'hE;
      SEG_CODE_F: o_nibble = 4'hF;
      default:    o_valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Debounces a multiplexed 7-segment bus, recovers each digit and emits full frames.
// Optional macro SEGDEC_ERR_EN: capture undecodable masks as 0 and flag the frame via outErr.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned STABLE = 3
) (
  input  logic                clk,
  input  logic                rstN,
  seg_scan_decoder_if.slave   bus
);

  localparam int unsigned CntW = $clog2(STABLE + 1);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DIGITS-1:0]   r_prev_sel;
  logic [6:0]          r_prev_mask;
  logic [CntW-1:0]     r_cnt;
  logic                r_captured;
  seg_state_e          r_state;
  logic [DIGITS-1:0]   r_filled;
  logic [4*DIGITS-1:0] r_slots;
  logic [4*DIGITS-1:0] r_word;

  logic            w_same;
  logic [CntW-1:0] w_cnt_d;
  logic            w_dwell_cap;
  logic            w_onehot;
  logic [IdxW-1:0] w_idx;
  logic            w_dec_valid;
  logic [3:0]      w_dec_nib;
  logic            w_accept;
  logic            w_full;
  logic            w_capture;

  seg_pattern_decode u_decode (
    .i_mask   (bus.segMask),
    .o_valid  (w_dec_valid),
    .o_nibble (w_dec_nib)
  );

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.digitSel[i]) w_idx = IdxW'(i);
    end
  end

  assign w_same      = (bus.digitSel == r_prev_sel) && (bus.segMask == r_prev_mask);
  assign w_cnt_d     = !w_same ? CntW'(1) :
                       (r_cnt == CntW'(STABLE)) ? r_cnt : r_cnt + CntW'(1);
  assign w_dwell_cap = w_same && r_captured;
  assign w_onehot    = (bus.digitSel != '0) &&
                       ((bus.digitSel & (bus.digitSel - DIGITS'(1))) == '0);
  assign w_full      = &r_filled;
`ifdef SEGDEC_ERR_EN
  assign w_accept    = 1'b1;
`else
  assign w_accept    = w_dec_valid;
`endif
  // Captures are blocked while a finished frame is waiting to move to HOLD.
  assign w_capture   = (r_state == StCollect) && !w_full && (w_cnt_d == CntW'(STABLE)) &&
                       w_onehot && !w_dwell_cap && w_accept;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_prev_sel  <= '0;
      r_prev_mask <= '0;
      r_cnt       <= '0;
      r_captured  <= 1'b0;
      r_state     <= StCollect;
      r_filled    <= '0;
      r_slots     <= '0;
      r_word      <= '0;
    end else begin
      r_prev_sel  <= bus.digitSel;
      r_prev_mask <= bus.segMask;
      r_cnt       <= w_cnt_d;
      r_captured  <= w_dwell_cap || w_capture;
      if (w_capture) begin
        r_slots[{w_idx, 2'b00} +: 4] <= w_dec_nib;
        r_filled[w_idx]              <= 1'b1;
      end
      case (r_state)
        StCollect: begin
          if (w_full) begin
            r_state <= StHold;
            r_word  <= r_slots;
          end
        end
        default: begin
          if (bus.outReady) begin
            r_state  <= StCollect;
            r_filled <= '0;
          end
        end
      endcase
    end
  end

`ifdef SEGDEC_ERR_EN
  logic [DIGITS-1:0] r_slot_err;
  logic              r_err;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_slot_err <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_capture) r_slot_err[w_idx] <= !w_dec_valid;
      if (r_state == StCollect && w_full) r_err <= |r_slot_err;
      if (r_state == StHold && bus.outReady) r_slot_err <= '0;
    end
  end

  assign bus.outErr = r_err;
`else
  assign bus.outErr = 1'b0;
`endif

  assign bus.outValid = (r_state == StHold);
  assign bus.outWord  = r_word;

endmodule
